chunked_adder: RTL and testbench
================================

# chunked_adder

Multi-cycle, parametrised N-bit adder/subtractor that processes its operands in W-bit slices, least-significant slice first, holding the inter-slice carry in a register. It is the area-lean successor to the single-cycle 64-bit RCA/CLA/prefix adders and trades latency for a W-bit carry chain. Operands enter and results leave through valid/ready handshakes, so it sits directly on a datapath stream. It is exercised by the same vector-file flow as the combinational adders, with the bench driving handshakes.

## Interface
- N, 64, operand and result width.
- W, 16, slice width. Must divide N; elaboration `$fatal` otherwise. W == N is legal and gives one compute cycle.
- clk input 1 — single clock. All state updates on the rising edge.
- rst_n input 1 — asynchronous, active-low reset.
- in_valid input 1 — operand request.
- in_ready output 1 — block can accept an operand set.
- a input N — operand A.
- b input N — operand B.
- cin input 1 — carry-in. Ignored when sub = 1.
- sub input 1 — 0: A+B+cin; 1: A−B, computed as A+~B+1.
- out_valid output 1 — result available.
- out_ready input 1 — consumer accepts the result.
- sum output N — result.
- cout output 1 — carry out of bit N−1. For subtraction, 1 means no borrow.
- ovf output 1 — signed overflow. Present only with ADDER_OVF_EN.

## Operation
- C = N/W slices; a slice counter idx has width max(1, $clog2(C)).
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid && in_ready:
    - latch a, and b (or ~b when sub = 1).
    - load the carry register with sub ? 1 : cin.
    - idx ← 0, then go to RUN.
- **RUN**, once per cycle:
  - sum slice[idx] ← a slice[idx] + b slice[idx] + carry.
  - carry ← carry out of the slice.
  - idx ← idx+1.
  - When idx == C−1, go to DONE after the write and set cout ← that slice's carry out.
- **DONE**
  - out_valid = 1.
  - sum, cout and ovf are held stable until out_valid && out_ready, then go to IDLE.
- in_ready is 0 in RUN and DONE. There is no operand overlap.
- Modular arithmetic: sum = (A + B + cin) mod 2^N, or (A − B) mod 2^N.
- Inputs are sampled only on the accepting edge. Later input changes have no effect.
- Reset values: state = IDLE, in_ready = 1 (combinational from IDLE), out_valid = 0, sum = 0, cout = 0, ovf = 0, carry = 0, idx = 0.
- Reset asserted mid-RUN or in DONE aborts the operation. The in-flight result is discarded and never presented.
- out_ready asserted outside DONE is ignored.

## Timing
- Acceptance edge t → RUN during cycles t+1 … t+C → out_valid high from edge t+C onward.
- Latency C cycles from acceptance to out_valid. With N=64, W=16 this is 4.
- out_valid && out_ready at edge u → in_ready high after u. The next acceptance is possible at u+1.
- Minimum initiation interval is C+2 cycles with out_ready held high.
- out_valid and in_ready are never high in the same cycle.

## Configuration
- ADDER_OVF_EN defined:
  - port ovf exists.
  - in the last RUN cycle, ovf ← (carry into bit N−1) XOR (carry out of bit N−1), registered with cout.
  - reset value 0.
- ADDER_OVF_EN undefined: no ovf port and no related logic.
- Behaviour of every other port is identical in both builds.

## Structure
- Package adder_pkg:
  - state enum adder_state_e {IDLE, RUN, DONE}.
  - function num_chunks(N, W).
  - localparam defaults DEF_N = 64 and DEF_W = 16, shared with rca, cla and prefix.
- One sub-module, chunk_add:
  - combinational W-bit slice adder: a_s, b_s, c_in → s, c_out.
  - exposes c_msb_in, the carry into its top bit, for ovf.
- The FSM, operand/result registers and counter live in chunked_adder.

## Test plan
- **Reset:** rst_n = 0 → out_valid = 0, sum = 0, cout = 0, in_ready = 1. Release, idle 3 cycles → out_valid stays 0.
- **Carry ripple across all slices:** N=64, W=16, a = FFFF_FFFF_FFFF_FFFF, b = 0, cin = 1, sub = 0 → after exactly 4 cycles sum = 0, cout = 1. With ADDER_OVF_EN, ovf = 0.
- **Subtract with borrow:** a = 0, b = 1, sub = 1, cin = 1 (cin is ignored) → sum = FFFF_FFFF_FFFF_FFFF, cout = 0. Then a = 5, b = 3 → sum = 2, cout = 1.
- **Signed overflow (ADDER_OVF_EN):** a = 7FFF_FFFF_FFFF_FFFF, b = 1, sub = 0, cin = 0 → sum = 8000_0000_0000_0000, ovf = 1, cout = 0.
- **Backpressure:** hold out_ready = 0 for 10 cycles after out_valid, toggling a and b → sum is unchanged and in_ready = 0. Raise out_ready → in_ready = 1 the next cycle. A back-to-back vector completes with correct results.
- **Mid-operation reset and W=N:** assert rst_n = 0 during the 2nd RUN cycle → out_valid never asserts and the next vector computes correctly. Rerun the vector file with W = 64 → every result arrives 1 cycle after acceptance.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the adder family (rca, cla, prefix, chunked).
// The chunked adder's ovf port and logic exist only when ADDER_OVF_EN is defined.
package adder_pkg;

  localparam int DEF_N = 64;
  localparam int DEF_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } adder_state_e;

  function automatic int num_chunks(input int n, input int w);
    return n / w;
  endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational W-bit slice adder used by chunked_adder.
// With ADDER_OVF_EN it also exposes the carry into its top bit.
module chunk_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_s,
  input  logic [W-1:0] b_s,
  input  logic         c_in,
  output logic [W-1:0] s,
  output logic         c_out
`ifdef ADDER_OVF_EN
  ,
  output logic         c_msb_in
`endif
);

  logic [W:0] full;

  assign full  = {1'b0, a_s} + {1'b0, b_s} + {{W{1'b0}}, c_in};
  assign s     = full[W-1:0];
  assign c_out = full[W];

`ifdef ADDER_OVF_EN
  // Top sum bit is a ^ b ^ carry-in, so the carry-in can be recovered from it.
  assign c_msb_in = a_s[W-1] ^ b_s[W-1] ^ full[W-1];
`endif

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle N-bit adder/subtractor, one W-bit slice per cycle, LSB slice first.
// Define ADDER_OVF_EN to add the registered signed-overflow output ovf.
module chunked_adder
  import adder_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout
`ifdef ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int C  = num_chunks(N, W);
  localparam int IW = (C > 1) ? $clog2(C) : 1;

  if ((N % W) != 0) begin : g_bad_slice
    $fatal(1, "chunked_adder: W must divide N");
  end

  adder_state_e  state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic          carry_q, carry_d, cout_q, cout_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_s, b_s, s_s;
  logic          c_out_s;
  int            base;

  assign base = int'(idx_q) * W;
  assign a_s  = a_q[base +: W];
  assign b_s  = b_q[base +: W];

`ifdef ADDER_OVF_EN
  logic ovf_q, ovf_d, c_msb_s;
`endif

  chunk_add #(.W(W)) u_slice (
    .a_s      (a_s),
    .b_s      (b_s),
    .c_in     (carry_q),
    .s        (s_s),
    .c_out    (c_out_s)
`ifdef ADDER_OVF_EN
    ,
    .c_msb_in (c_msb_s)
`endif
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef ADDER_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Subtraction is A + ~B + 1: invert B once here, seed carry with 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: W] = s_s;
        carry_d          = c_out_s;
        idx_d            = idx_q + IW'(1);
        if (idx_q == IW'(C - 1)) begin
          cout_d  = c_out_s;
          idx_d   = '0;
          state_d = DONE;
`ifdef ADDER_OVF_EN
          ovf_d   = c_msb_s ^ c_out_s;
`endif
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
`ifdef ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder: a W=16 instance and a W=64 (single-slice) instance.
module tb_chunked_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv, ordy, sel;
  logic [63:0] a, b;
  logic        cin, sub;

  logic        in_ready0, out_valid0, cout0;
  logic        in_ready1, out_valid1, cout1;
  logic [63:0] sum0, sum1;
  logic        in_ready_v, out_valid_v, cout_v;
  logic [63:0] sum_v;
`ifdef ADDER_OVF_EN
  logic        ovf0, ovf1, ovf_v;
  assign ovf_v = sel ? ovf1 : ovf0;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  chunked_adder #(.N(64), .W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv & ~sel), .in_ready(in_ready0),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid0), .out_ready(ordy & ~sel), .sum(sum0), .cout(cout0)
`ifdef ADDER_OVF_EN
    , .ovf(ovf0)
`endif
  );

  chunked_adder #(.N(64), .W(64)) u_dut_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv & sel), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid1), .out_ready(ordy & sel), .sum(sum1), .cout(cout1)
`ifdef ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  assign in_ready_v  = sel ? in_ready1  : in_ready0;
  assign out_valid_v = sel ? out_valid1 : out_valid0;
  assign sum_v       = sel ? sum1       : sum0;
  assign cout_v      = sel ? cout1      : cout0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where out_valid is first seen.
  task automatic start_op(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                          input logic tcin, input logic tsub, input logic [63:0] esum,
                          input logic ecout, input logic eovf, input int elat);
    int lat;
    a = ta; b = tb; cin = tcin; sub = tsub; iv = 1'b1;
    chk({tag, "_in_ready"}, 64'(in_ready_v), 64'd1);
    @(negedge clk);
    iv = 1'b0;
    lat = 0;
    while (!out_valid_v && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(elat));
    chk({tag, "_sum"}, sum_v, esum);
    chk({tag, "_cout"}, 64'(cout_v), 64'(ecout));
    chk({tag, "_no_in_ready"}, 64'(in_ready_v), 64'd0);
`ifdef ADDER_OVF_EN
    chk({tag, "_ovf"}, 64'(ovf_v), 64'(eovf));
`else
    if (eovf === 1'bx) $display("unexpected x");
`endif
  endtask

  task automatic release_out(input string tag);
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    chk({tag, "_out_valid_drop"}, 64'(out_valid_v), 64'd0);
    chk({tag, "_in_ready_back"}, 64'(in_ready_v), 64'd1);
  endtask

  initial begin
    int seen;
    logic [63:0] held;
    rst_n = 1'b0; iv = 1'b0; ordy = 1'b0; sel = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    #3;
    chk("rst_out_valid", 64'(out_valid0), 64'd0);
    chk("rst_sum", sum0, 64'd0);
    chk("rst_cout", 64'(cout0), 64'd0);
    chk("rst_in_ready", 64'(in_ready0), 64'd1);
    chk("rst_w64_in_ready", 64'(in_ready1), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid0) seen++;
    end
    chk("idle_out_valid", 64'(seen), 64'd0);

    start_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 4);
    release_out("ripple");
    start_op("sub_borrow", 64'h0, 64'h1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 4);
    release_out("sub_borrow");
    start_op("sub_5_3", 64'h5, 64'h3, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0, 4);
    release_out("sub_5_3");
    start_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1, 4);
    release_out("sovf");

    start_op("bp", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
             64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 4);
    held = 64'h1234_5678_9ABC_DF00;
    for (int i = 0; i < 10; i++) begin
      a = ~a; b = b + 64'h0101; cin = ~cin; sub = ~sub; iv = 1'b1;
      @(negedge clk);
      chk("bp_sum_held", sum0, held);
      chk("bp_in_ready_low", 64'(in_ready0), 64'd0);
    end
    iv = 1'b0;
    chk("bp_out_valid_held", 64'(out_valid0), 64'd1);
    release_out("bp");
    start_op("b2b", 64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 1'b0,
             64'h0000_0001_0000_0000, 1'b1, 1'b0, 4);
    release_out("b2b");

    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; cin = 1'b1; sub = 1'b0; iv = 1'b1;
    @(negedge clk);
    iv = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid0), 64'd0);
    chk("midrst_sum", sum0, 64'd0);
    chk("midrst_in_ready", 64'(in_ready0), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid0) seen++;
    end
    chk("midrst_never_valid", 64'(seen), 64'd0);
    start_op("after_rst", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
             64'h0, 1'b1, 1'b1, 4);
    release_out("after_rst");

    sel = 1'b1;
    start_op("w64_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1);
    release_out("w64_ripple");
    start_op("w64_sub_borrow", 64'h0, 64'h1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1);
    release_out("w64_sub_borrow");
    start_op("w64_b2b", 64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 1'b0,
             64'h0000_0001_0000_0000, 1'b1, 1'b0, 1);
    release_out("w64_b2b");
    start_op("w64_sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1, 1);
    release_out("w64_sovf");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
